// File: rtl/lau_pkg.sv
// Shared types for the arithmetic unit library.
// Holds adder speed selection and accumulator FSM states.
package lau_pkg;

  typedef enum logic {
    SLOW,
    FAST
  } speed_e;

  typedef enum logic {
    IDLE,
    RUN
  } sqr_acc_state_e;

endpackage

// File: rtl/Add.sv
// Unsigned adder; FAST maps to the native operator, SLOW is
// an explicit ripple-carry chain.
module Add
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] sum_o
);

  if (speed == FAST) begin : g_fast
    assign sum_o = a_i + b_i;
  end else begin : g_rca
    logic [width-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < width; i++) begin : g_bit
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      if (i < width - 1) begin : g_c
        assign c[i+1] = (a_i[i] & b_i[i])
                      | (c[i] & (a_i[i] ^ b_i[i]));
      end
    end
  end

endmodule

// File: rtl/sqr_acc_sgn.sv
// Per-frame sum-of-squares accumulator with registered result handshake.
// Define SQR_ACC_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module sqr_acc_sgn
  import lau_pkg::*;
#(
  parameter int     width    = 8,
  parameter int     cntWidth = 8,
  parameter speed_e speed    = FAST
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2*width-1:0]         sq_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [2*width+cntWidth-1:0] acc_o,
  output logic [cntWidth:0]          cnt_o,
  output logic                       ovf_o
);

  localparam int AW = 2 * width + cntWidth;
  localparam int CW = cntWidth + 1;

  sqr_acc_state_e state_q, state_d;

  logic [AW-1:0] acc_q, acc_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          ovf_q, ovf_nxt;
  logic [AW:0]   sum;
  logic          carry;
  logic          accept;

  assign in_ready_o = ~out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  Add #(
    .width(AW + 1),
    .speed(speed)
  ) u_add (
    .a_i  ({1'b0, acc_q}),
    .b_i  ({{CW{1'b0}}, sq_i}),
    .sum_o(sum)
  );

  assign carry = sum[AW];

  // MSB of the count set means this sample exceeds the nominal frame length
  always_comb begin
    cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    ovf_nxt = ovf_q | carry | cnt_q[CW-1];
`ifdef SQR_ACC_SATURATE_EN
    acc_nxt = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
    acc_nxt = sum[AW-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last_i ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_o <= 1'b0;
      acc_o       <= '0;
      cnt_o       <= '0;
      ovf_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (in_last_i) begin
          acc_o <= acc_nxt;
          cnt_o <= cnt_nxt;
          ovf_o <= ovf_nxt;
          acc_q <= '0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_nxt;
          ovf_q <= ovf_nxt;
        end
      end
      if (accept & in_last_i) begin
        out_valid_o <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sqr_acc_sgn.sv
// Bench for sqr_acc_sgn: table frames, corner sequences, random frames.
// Second instance with cntWidth=0 exercises overflow.
module tb_sqr_acc_sgn;
  import lau_pkg::*;

  localparam int AW = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, rdy, lst, ovld, ordy, ovf;
  logic [15:0] sq;
  logic [23:0] acc;
  logic [8:0]  cnt;

  logic        v0, rdy0, l0, ovld0, r0, ovf0;
  logic [15:0] sq0;
  logic [15:0] acc0;
  logic [0:0]  cnt0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] acc;
    logic [8:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          x0, x1, x2;
    int          n;
    logic [23:0] acc;
    logic [8:0]  cnt;
    logic        ovf;
  } vec_t;

  exp_t q[$];
  exp_t e;

  longint m_acc;
  int     m_n;
  bit     m_ovf;

  always #5 clk = ~clk;

  sqr_acc_sgn #(.width(8), .cntWidth(8), .speed(FAST)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (vld),
    .in_ready_o (rdy),
    .sq_i       (sq),
    .in_last_i  (lst),
    .out_valid_o(ovld),
    .out_ready_i(ordy),
    .acc_o      (acc),
    .cnt_o      (cnt),
    .ovf_o      (ovf)
  );

  sqr_acc_sgn #(.width(8), .cntWidth(0), .speed(SLOW)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (v0),
    .in_ready_o (rdy0),
    .sq_i       (sq0),
    .in_last_i  (l0),
    .out_valid_o(ovld0),
    .out_ready_i(r0),
    .acc_o      (acc0),
    .cnt_o      (cnt0),
    .ovf_o      (ovf0)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_n   = 0;
    m_ovf = 0;
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) ordy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input bit last, input bit rnd,
                      input bit push);
    int     t;
    longint s;
    bit     c;
    exp_t   ex;
    t   = 0;
    sq  = 16'(x * x);
    lst = last;
    vld = 1'b1;
    if (rnd) ordy = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (rdy) break;
      t++;
      if (t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %0d", rdy);
        vld = 1'b0;
        lst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (rnd) ordy = 1'($urandom_range(0, 1));
    end
    s = m_acc + longint'(x * x);
    c = s >= (64'd1 << AW);
    m_n++;
    if (c || m_n > 256) m_ovf = 1;
`ifdef SQR_ACC_SATURATE_EN
    m_acc = c ? (64'd1 << AW) - 1 : s;
`else
    m_acc = s % (64'd1 << AW);
`endif
    if (last) begin
      ex.acc = 24'(m_acc);
      ex.cnt = 9'(m_n > 511 ? 511 : m_n);
      ex.ovf = m_ovf;
      if (push) q.push_back(ex);
      model_clear();
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    lst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ovld && ordy) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got acc %0d expected none", acc);
      end else begin
        e = q.pop_front();
        chk("out_acc", 64'(acc), 64'(e.acc));
        chk("out_cnt", 64'(cnt), 64'(e.cnt));
        chk("out_ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    exp_t tx;
    logic [15:0] exp0;
    int len;

    tbl[0] = '{x0: 3, x1: -4, x2: 5, n: 3, acc: 50, cnt: 3, ovf: 0};
    tbl[1] = '{x0: -128, x1: 0, x2: 0, n: 1, acc: 16384, cnt: 1, ovf: 0};
    tbl[2] = '{x0: 1, x1: 0, x2: 0, n: 1, acc: 1, cnt: 1, ovf: 0};
    tbl[3] = '{x0: 2, x1: 0, x2: 0, n: 1, acc: 4, cnt: 1, ovf: 0};

    rst  = 1'b1;
    vld  = 1'b0;
    lst  = 1'b0;
    sq   = '0;
    ordy = 1'b1;
    v0   = 1'b0;
    l0   = 1'b0;
    sq0  = '0;
    r0   = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(ovld), 0);
    chk("rst_acc", 64'(acc), 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_ready", 64'(rdy), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      int xs[3];
      xs[0] = tbl[i].x0;
      xs[1] = tbl[i].x1;
      xs[2] = tbl[i].x2;
      tx.acc = tbl[i].acc;
      tx.cnt = tbl[i].cnt;
      tx.ovf = tbl[i].ovf;
      q.push_back(tx);
      for (int j = 0; j < tbl[i].n; j++)
        send(xs[j], j == tbl[i].n - 1, 0, 0);
      if (i == 3) begin
        @(negedge clk);
        chk("b2b_valid", 64'(ovld), 1);
        @(posedge clk);
        #1;
      end
    end
    idle(3, 0);

    ordy = 1'b0;
    tx = '{acc: 49, cnt: 1, ovf: 0};
    q.push_back(tx);
    send(7, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(rdy), 0);
      chk("bp_valid", 64'(ovld), 1);
      chk("bp_acc", 64'(acc), 49);
      @(posedge clk);
      #1;
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(rdy), 1);
    @(posedge clk);
    #1;
    idle(2, 0);

    send(10, 0, 0, 1);
    send(10, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("mid_rst_valid", 64'(ovld), 0);
    chk("mid_rst_acc", 64'(acc), 0);
    chk("mid_rst_cnt", 64'(cnt), 0);
    chk("mid_rst_ovf", 64'(ovf), 0);
    @(posedge clk);
    #1;
    tx = '{acc: 4, cnt: 1, ovf: 0};
    q.push_back(tx);
    send(2, 1, 0, 0);
    idle(2, 0);

`ifdef SQR_ACC_SATURATE_EN
    exp0 = 16'hffff;
`else
    exp0 = 16'd16384;
`endif
    sq0 = 16'd16384;
    v0  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      l0 = (k == 4);
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    l0 = 1'b0;
    @(negedge clk);
    chk("c0_valid", 64'(ovld0), 1);
    chk("c0_acc", 64'(acc0), 64'(exp0));
    chk("c0_cnt", 64'(cnt0), 1);
    chk("c0_ovf", 64'(ovf0), 1);
    @(posedge clk);
    #1;

    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        idle($urandom_range(0, 1), 1);
        send(int'($urandom_range(0, 255)) - 128, j == len - 1, 1, 1);
      end
    end
    ordy = 1'b1;
    idle(5, 0);
    chk("queue_drained", 64'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
